// File: rtl/abro_pkg.sv
// Shared types and constants for the ABRO stimulus sequencer.
package abro_pkg;

  // FSM state encoding; value 7 is unused and recovers to IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_EV1    = 3'd2,
    ST_GAP    = 3'd3,
    ST_EV2    = 3'd4,
    ST_WAIT   = 3'd5,
    ST_REPORT = 3'd6
  } state_t;

  // Run modes
  localparam logic [1:0] MODE_AB     = 2'b00;
  localparam logic [1:0] MODE_BA     = 2'b01;
  localparam logic [1:0] MODE_SIM    = 2'b10;
  localparam logic [1:0] MODE_A_ONLY = 2'b11;

  // Default timing
  localparam int unsigned TIMEOUT_DEF  = 8;
  localparam int unsigned R_CYCLES_DEF = 2;

  // Modes that issue two separate events with a programmable gap between them
  function automatic logic mode_two_events(input logic [1:0] m);
    return (m == MODE_AB) || (m == MODE_BA);
  endfunction

endpackage

// File: rtl/abro_seq_timer.sv
// Loadable down-counter with zero flag, shared by the RST, GAP and WAIT phases.
module abro_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/abro_event_sequencer.sv
// ABRO initiator: resets the responder, issues A/B events, times the O response
// and reports pass/fail plus latency for each run.
module abro_event_sequencer
  import abro_pkg::*;
#(
  parameter int unsigned GAP_W    = 4,
  parameter int unsigned LAT_W    = 4,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned R_CYCLES = R_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic             o_in,
  output logic             r_n_out,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [LAT_W-1:0] latency,
  output logic [2:0]       state
);

  localparam int unsigned CNT_W = (GAP_W > LAT_W) ? GAP_W : LAT_W;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [GAP_W-1:0]   gap_q;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]   tmr_load_val, tmr_count;

  logic               accept;
  logic               set_result;
  logic               pass_d;
  logic [LAT_W-1:0]   latency_d;

  logic               r_n_d, a_d, b_d, done_d;

  abro_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, timer control and run result
  // Each timed phase loads N-1 and leaves on the zero flag, so it lasts N cycles.
  // In WAIT the remaining count including the current cycle is count+1, which
  // makes the latency TIMEOUT - (count+1) + 1 = TIMEOUT - count.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = '0;
    accept       = 1'b0;
    set_result   = 1'b0;
    pass_d       = 1'b0;
    latency_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_d      = ST_RST;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(R_CYCLES - 1);
        end
      end
      ST_RST: begin
        if (tmr_zero) state_d = ST_EV1;
        else          tmr_dec = 1'b1;
      end
      ST_EV1: begin
        if (o_in) begin
          state_d    = ST_REPORT;
          set_result = 1'b1;
        end else if (!mode_two_events(mode_q)) begin
          state_d      = ST_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(TIMEOUT - 1);
        end else if (gap_q != '0) begin
          state_d      = ST_GAP;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(gap_q) - CNT_W'(1);
        end else begin
          state_d = ST_EV2;
        end
      end
      ST_GAP: begin
        if (o_in) begin
          state_d    = ST_REPORT;
          set_result = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_EV2;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_EV2: begin
        if (o_in) begin
          state_d    = ST_REPORT;
          set_result = 1'b1;
        end else begin
          state_d      = ST_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(TIMEOUT - 1);
        end
      end
      ST_WAIT: begin
        if (o_in) begin
          state_d    = ST_REPORT;
          set_result = 1'b1;
          pass_d     = (mode_q != MODE_A_ONLY);
          latency_d  = pass_d ? (LAT_W'(TIMEOUT) - LAT_W'(tmr_count)) : '0;
        end else if (tmr_zero) begin
          state_d    = ST_REPORT;
          set_result = 1'b1;
          pass_d     = (mode_q == MODE_A_ONLY);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered pulses align with it
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    r_n_d  = (state_d != ST_RST);
    done_d = (state_d == ST_REPORT);
    case (state_d)
      ST_EV1: begin
        a_d = (mode_q != MODE_BA);
        b_d = (mode_q == MODE_BA) || (mode_q == MODE_SIM);
      end
      ST_EV2: begin
        a_d = (mode_q == MODE_BA);
        b_d = (mode_q == MODE_AB);
      end
      default: ;
    endcase
  end

  // Registered responder stimulus and done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_n_out <= 1'b1;
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_n_out <= r_n_d;
      a_out   <= a_d;
      b_out   <= b_d;
      done    <= done_d;
    end
  end

  // Run context and held result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q  <= MODE_AB;
      gap_q   <= '0;
      pass    <= 1'b0;
      latency <= '0;
    end else if (accept) begin
      mode_q  <= mode;
      gap_q   <= gap;
      pass    <= 1'b0;
      latency <= '0;
    end else if (set_result) begin
      pass    <= pass_d;
      latency <= latency_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_abro_event_sequencer.sv
// Bench for abro_event_sequencer: directed and random runs checked against a
// timeline model derived from the run rules.
module tb_abro_event_sequencer;

  localparam int R_CYC = 2;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       reset_n, start, o_in;
  logic [1:0] mode;
  logic [3:0] gap;
  logic       r_n_out, a_out, b_out, busy, done, pass;
  logic [3:0] latency;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int prev_pass = 0;
  int prev_lat  = 0;
  int run_id    = 0;

  abro_event_sequencer #(
    .GAP_W    (4),
    .LAT_W    (4),
    .TIMEOUT  (TO),
    .R_CYCLES (R_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .gap     (gap),
    .o_in    (o_in),
    .r_n_out (r_n_out),
    .a_out   (a_out),
    .b_out   (b_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .latency (latency),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string pfx, input int st, input int bsy, input int dn,
                         input int rn, input int a, input int b, input int p, input int l);
    chk({pfx, " state"},   32'(state),   st);
    chk({pfx, " busy"},    32'(busy),    bsy);
    chk({pfx, " done"},    32'(done),    dn);
    chk({pfx, " r_n_out"}, 32'(r_n_out), rn);
    chk({pfx, " a_out"},   32'(a_out),   a);
    chk({pfx, " b_out"},   32'(b_out),   b);
    chk({pfx, " pass"},    32'(pass),    p);
    chk({pfx, " latency"}, 32'(latency), l);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    o_in  = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 1, 0, 0, prev_pass, prev_lat);
      mode = 2'($urandom);
      gap  = 4'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // One run, timed from the cycle in which start is presented (cycle 0).
  // o_at: cycle in which o_in is pulsed (-1 none). abort_at: cycle with reset_n low.
  task automatic do_run(input logic [1:0] m, input int g, input int o_at,
                        input bit want_spur, input int abort_at);
    bit two, a1, b1, a2, b2;
    int ev1, ev2, last, rep, ep, el, spur, st;
    string pfx;
    run_id++;
    two  = (m == 2'b00) || (m == 2'b01);
    a1   = (m != 2'b01);
    b1   = (m == 2'b01) || (m == 2'b10);
    a2   = (m == 2'b01);
    b2   = (m == 2'b00);
    ev1  = R_CYC + 1;
    ev2  = two ? R_CYC + 2 + g : -1;
    last = two ? ev2 : ev1;
    if (o_at >= ev1 && o_at <= last) begin
      rep = o_at + 1; ep = 0; el = 0;
    end else if (o_at > last && o_at <= last + TO) begin
      rep = o_at + 1; ep = (m != 2'b11) ? 1 : 0; el = ep ? o_at - last : 0;
    end else begin
      rep = last + TO + 1; ep = (m == 2'b11) ? 1 : 0; el = 0;
    end
    spur = want_spur ? int'($urandom_range(rep - 1, 1)) : -1;

    for (int c = 0; c <= rep; c++) begin
      pfx = $sformatf("run%0d c%0d", run_id, c);
      if (c == 0) begin
        chk_all(pfx, 0, 0, 0, 1, 0, 0, prev_pass, prev_lat);
      end else begin
        if (c == rep)                  st = 6;
        else if (c <= R_CYC)           st = 1;
        else if (c == ev1)             st = 2;
        else if (two && c < ev2)       st = 3;
        else if (two && c == ev2)      st = 4;
        else                           st = 5;
        chk_all(pfx, st, 1, (c == rep) ? 1 : 0, (c <= R_CYC) ? 0 : 1,
                (c < rep && ((c == ev1 && a1) || (two && c == ev2 && a2))) ? 1 : 0,
                (c < rep && ((c == ev1 && b1) || (two && c == ev2 && b2))) ? 1 : 0,
                (c == rep) ? ep : 0, (c == rep) ? el : 0);
      end
      start = (c == 0) || (c == spur);
      mode  = (c == 0) ? m : 2'($urandom);
      gap   = (c == 0) ? 4'(g) : 4'($urandom);
      o_in  = (c == o_at);
      if (c == abort_at) reset_n = 1'b0;
      @(posedge clk); #1;
      if (c == abort_at) begin
        reset_n = 1'b1;
        start   = 1'b0;
        o_in    = 1'b0;
        chk_all({pfx, " abort"}, 0, 0, 0, 1, 0, 0, 0, 0);
        prev_pass = 0;
        prev_lat  = 0;
        return;
      end
    end
    start     = 1'b0;
    o_in      = 1'b0;
    prev_pass = ep;
    prev_lat  = el;
  endtask

  initial begin
    int o_at;
    reset_n = 1'b0;
    start   = 1'b1;
    mode    = 2'b00;
    gap     = 4'd0;
    o_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    start   = 1'b0;
    idle(2);

    // A-then-B, gap 2, O one edge after B: latency 1
    do_run(2'b00, 2, R_CYC + 2 + 2 + 1, 1'b0, -1);
    // Simultaneous A+B, O three edges later
    do_run(2'b10, 5, R_CYC + 1 + 3, 1'b0, -1);
    // A only, silent responder: pass on timeout
    do_run(2'b11, 0, -1, 1'b0, -1);
    // B-then-A, gap 0, silent responder: fail on timeout
    do_run(2'b01, 0, -1, 1'b0, -1);
    // O during GAP with a stray start while busy
    do_run(2'b00, 3, R_CYC + 2, 1'b1, -1);
    // O in the final WAIT cycle: maximum latency
    do_run(2'b00, 0, R_CYC + 2 + TO, 1'b0, -1);
    // O one cycle too late: timeout
    do_run(2'b01, 1, R_CYC + 3 + TO + 1, 1'b0, -1);
    // O in A-only mode: fail
    do_run(2'b11, 0, R_CYC + 1 + 2, 1'b0, -1);
    // O coincident with the simultaneous event: premature
    do_run(2'b10, 0, R_CYC + 1, 1'b0, -1);
    // O while the responder is held in reset: ignored
    do_run(2'b00, 1, R_CYC, 1'b0, -1);
    idle(1);
    // Reset mid-WAIT, then a normal run
    do_run(2'b11, 0, -1, 1'b0, R_CYC + 1 + 4);
    do_run(2'b00, 1, R_CYC + 3 + 2, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(4, 0) == 0) o_at = -1;
      else o_at = int'($urandom_range(R_CYC + 2 + 15 + TO + 2, 0));
      do_run(2'($urandom), int'($urandom_range(15, 0)), o_at,
             1'($urandom), -1);
      if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
